icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller's IF port. Hits return the instruction combinationally in the request cycle. Misses issue a single 4-byte fetch to the memory controller, hold it until completion, fill the line, and forward the word. A rollback flush cancels forwarding without aborting the in-flight memory access, because the memory controller cannot abort.

## Interface
Parameters:
- `IDX_W`, default 4: index bits, giving 2^IDX_W lines.
- Tag width is 30-IDX_W (address bits [31:2+IDX_W]). Address bits [1:0] are ignored.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global enable. When low, all state is frozen.
- `fetch_req` in 1: IF stage requests the instruction at `fetch_pc`.
- `fetch_pc` in 32: fetch address, word-aligned.
- `inst_valid` out 1: `inst_out` is valid for `fetch_pc` this cycle.
- `inst_out` out 32: instruction word.
- `clear` in 1: rollback/flush of the fetch stream.
- `inst_IF_req` out 1: request to the memory controller.
- `inst_IF_addr` out 32: miss address to the memory controller.
- `inst_IF_flag` in 1: memory controller completion pulse.
- `inst_IF` in 32: fetched word, valid only in the `inst_IF_flag` cycle.

## Operation
Storage:
- Per line: `valid`, `tag[29-IDX_W:0]`, `data[31:0]`.
- Index = `fetch_pc[IDX_W+1:2]`.
- Hit = `valid[idx] && tag[idx] == fetch_pc[31:IDX_W+2]`.

States are IDLE and MISS. The state register, `miss_addr`, and `drop` are registers.

IDLE:
- `fetch_req && hit && !clear` gives `inst_valid` = 1 and `inst_out` = `data[idx]`, in the same cycle.
- `fetch_req && !hit && !clear` latches `miss_addr` = {`fetch_pc[31:2]`, 2'b00}, sets `drop` = 0, and goes to MISS.
- With `clear` = 1, no hit is reported and no miss is started.

MISS:
- `inst_IF_req` = `!inst_IF_flag`. This is combinational, so the request falls in the completion cycle and the memory controller does not restart a fetch.
- `inst_IF_addr` = `miss_addr`, held stable for the entire miss.
- `clear` in MISS sets `drop` = 1 and leaves the request outstanding.
- When `inst_IF_flag` = 1, in that cycle:
  - Write `valid` = 1, `tag`, and `data` = `inst_IF` at the `miss_addr` index.
  - If `!drop && !clear && fetch_req && fetch_pc == miss_addr`, drive `inst_valid` = 1 and `inst_out` = `inst_IF`.
  - Next state is IDLE.
- Hits are not served while in MISS; there is no hit-under-miss, and `inst_valid` = 0 except in the fill cycle.

In IDLE, `inst_IF_req` = 0 and `inst_IF_addr` = `miss_addr`.

When `rdy` = 0:
- No state, line, or `drop` update.
- `inst_valid` is forced to 0.
- `inst_IF_req` keeps its combinational value. The memory controller is also frozen.

Cache lines are never invalidated except by reset. Instruction memory is treated as read-only.

## Timing
Reset values:
- State = IDLE, all `valid` = 0, `drop` = 0, `miss_addr` = 0.
- `inst_IF_req` = 0, `inst_valid` = 0, `inst_out` = 0, `inst_IF_addr` = 0.
- Tag and data arrays need not be reset.

Hit latency is 0 cycles (combinational).

Miss latency:
- Request asserted from cycle t+1, the first MISS cycle.
- With no LSB contention, the memory controller pulses `inst_IF_flag` at t+5 (4 byte steps plus 1).
- The fill and forward happen at t+5, and IDLE is reached at t+6.
- LSB contention stretches the miss arbitrarily. `inst_IF_req` and `inst_IF_addr` must stay constant throughout.

Boundary cases:
- **Reset asserted mid-MISS:** immediately return to IDLE, drop the request, and forget the line being filled. The system reset also resets the memory controller.
- **`clear` and `inst_IF_flag` in the same cycle:** the line is filled, nothing is forwarded, and the next state is IDLE.
- **Fill to an index holding a valid line:** overwrite it (a tag conflict).
- **`fetch_pc` changes during MISS:** the fill still targets `miss_addr`. Forwarding happens only on an exact match; otherwise the IF stage re-requests in IDLE.

## Test plan
- **Cold miss:** reset, then `fetch_req` with `fetch_pc` = 0x0000_0010 and memory word 0x0000_0513.
  - Required: `inst_IF_req` high with address 0x10 for 4 cycles.
  - At `inst_IF_flag`: `inst_valid` = 1, `inst_out` = 0x0000_0513, and `inst_IF_req` low in that cycle.
- **Hit:** repeat `fetch_pc` = 0x10 after the fill.
  - Required: `inst_valid` = 1 in the same cycle, 0x0000_0513, and no `inst_IF_req`.
- **Conflict (IDX_W = 4):** fill 0x10, then fetch 0x50 (same index, different tag).
  - Required: a miss is issued for 0x50.
  - A subsequent 0x10 fetch misses again.
- **Flush mid-miss:** pulse `clear` two cycles into a miss for 0x20.
  - Required: the request stays asserted until `inst_IF_flag`, and `inst_valid` stays 0.
  - A later fetch of 0x20 hits.
- **LSB contention:** stall the memory controller's IF steps for 6 cycles mid-miss.
  - Required: `inst_IF_req` and `inst_IF_addr` stay stable, and a single fill occurs.
- **Async reset mid-miss:** drop `rst` between clock edges.
  - Required: `inst_IF_req` = 0 immediately, and all lines are invalid afterwards (a fetch of 0x10 misses).

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache.
// Hits answer combinationally in the request cycle. A miss issues one word
// fetch to the memory controller and holds it until the completion pulse.
// A flush during a miss only suppresses forwarding, because the memory
// controller cannot abandon an access that has started.
module icache #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  input  logic        clear,
  output logic        inst_IF_req,
  output logic [31:0] inst_IF_addr,
  input  logic        inst_IF_flag,
  input  logic [31:0] inst_IF
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t      state_reg, state_next;
  logic [31:0] miss_addr_reg, miss_addr_next;
  logic        drop_reg, drop_next;

  logic             valid_reg [LINES];
  logic [TAG_W-1:0] tag_mem   [LINES];
  logic [31:0]      data_mem  [LINES];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill_we;
  logic             pc_matches_miss;
  logic             unused_pc_bits;

  assign req_idx  = fetch_pc[IDX_W+1:2];
  assign req_tag  = fetch_pc[31:IDX_W+2];
  assign fill_idx = miss_addr_reg[IDX_W+1:2];
  assign fill_tag = miss_addr_reg[31:IDX_W+2];
  assign hit      = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);

  // The byte offset inside a word never selects anything.
  assign unused_pc_bits  = ^fetch_pc[1:0];
  assign pc_matches_miss = (fetch_pc[31:2] == miss_addr_reg[31:2]);

  // A line is written only on the completion pulse of a live (unfrozen) miss.
  assign fill_we = rdy && (state_reg == MISS) && inst_IF_flag;

  assign inst_IF_addr = miss_addr_reg;

  // Control registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      miss_addr_reg <= 32'h0;
      drop_reg      <= 1'b0;
    end else if (rdy) begin
      state_reg     <= state_next;
      miss_addr_reg <= miss_addr_next;
      drop_reg      <= drop_next;
    end
  end

  // Valid bits are the only per-line state cleared by reset.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_we && (fill_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data storage: written on fill, read asynchronously for the hit path.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= inst_IF;
    end
  end

  // Next-state and output decode for the IDLE/MISS controller.
  always_comb begin
    state_next     = state_reg;
    miss_addr_next = miss_addr_reg;
    drop_next      = drop_reg;
    inst_valid     = 1'b0;
    inst_out       = 32'h0;
    inst_IF_req    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fetch_req && !clear) begin
          if (hit) begin
            inst_valid = rdy;
            inst_out   = rdy ? data_mem[req_idx] : 32'h0;
          end else begin
            miss_addr_next = {fetch_pc[31:2], 2'b00};
            drop_next      = 1'b0;
            state_next     = MISS;
          end
        end
      end

      MISS: begin
        // Dropping the request in the completion cycle keeps the memory
        // controller from starting a second fetch.
        inst_IF_req = !inst_IF_flag;
        if (clear) begin
          drop_next = 1'b1;
        end
        if (inst_IF_flag) begin
          state_next = IDLE;
          if (!drop_reg && !clear && fetch_req && pc_matches_miss) begin
            inst_valid = rdy;
            inst_out   = rdy ? inst_IF : 32'h0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of the instruction cache with a hand-driven
// memory-controller completion pulse.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic        clear;
  logic        inst_IF_req;
  logic [31:0] inst_IF_addr;
  logic        inst_IF_flag;
  logic [31:0] inst_IF;

  int n_assert = 0;
  int n_fail   = 0;

  icache #(.IDX_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .fetch_req    (fetch_req),
    .fetch_pc     (fetch_pc),
    .inst_valid   (inst_valid),
    .inst_out     (inst_out),
    .clear        (clear),
    .inst_IF_req  (inst_IF_req),
    .inst_IF_addr (inst_IF_addr),
    .inst_IF_flag (inst_IF_flag),
    .inst_IF      (inst_IF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: request pc, expect a miss, watch the request for 4+stall
  // cycles, then pulse completion with word and expect it forwarded.
  task automatic miss_seq(input logic [31:0] pc, input logic [31:0] word,
                          input int stall, input string tag);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    #1;
    chk({tag, "_idle_valid"}, {31'b0, inst_valid}, 32'h0);
    chk({tag, "_idle_req"}, {31'b0, inst_IF_req}, 32'h0);
    for (int i = 0; i < 4 + stall; i++) begin
      cyc();
      #1;
      chk({tag, "_req"}, {31'b0, inst_IF_req}, 32'h1);
      chk({tag, "_addr"}, inst_IF_addr, pc);
      chk({tag, "_wait_valid"}, {31'b0, inst_valid}, 32'h0);
    end
    cyc();
    inst_IF_flag = 1'b1;
    inst_IF      = word;
    #1;
    chk({tag, "_fwd_valid"}, {31'b0, inst_valid}, 32'h1);
    chk({tag, "_fwd_data"}, inst_out, word);
    chk({tag, "_flag_req"}, {31'b0, inst_IF_req}, 32'h0);
    cyc();
    inst_IF_flag = 1'b0;
    inst_IF      = 32'h0;
    fetch_req    = 1'b0;
  endtask

  // Same cycle hit check for pc.
  task automatic hit_chk(input logic [31:0] pc, input logic [31:0] word, input string tag);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    #1;
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'h1);
    chk({tag, "_data"}, inst_out, word);
    chk({tag, "_req"}, {31'b0, inst_IF_req}, 32'h0);
    cyc();
    fetch_req = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    rdy          = 1'b1;
    fetch_req    = 1'b0;
    fetch_pc     = 32'h0;
    clear        = 1'b0;
    inst_IF_flag = 1'b0;
    inst_IF      = 32'h0;

    // Reset state.
    #2;
    chk("rst_req", {31'b0, inst_IF_req}, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_out", inst_out, 32'h0);
    chk("rst_addr", inst_IF_addr, 32'h0);
    #11;
    rst = 1'b1;
    cyc();

    // Cold miss then hit on 0x10.
    miss_seq(32'h0000_0010, 32'h0000_0513, 0, "cold");
    hit_chk(32'h0000_0010, 32'h0000_0513, "hit10");

    // Same index, different tag: 0x50 evicts 0x10, which then misses again.
    miss_seq(32'h0000_0050, 32'h0000_0093, 0, "conf50");
    hit_chk(32'h0000_0050, 32'h0000_0093, "hit50");
    miss_seq(32'h0000_0010, 32'h0000_0513, 0, "refill10");

    // Flush two cycles into a miss for 0x20.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_0020;
    #1;
    chk("fl_idle_valid", {31'b0, inst_valid}, 32'h0);
    cyc();
    #1;
    chk("fl_req1", {31'b0, inst_IF_req}, 32'h1);
    cyc();
    clear = 1'b1;
    #1;
    chk("fl_req_clear", {31'b0, inst_IF_req}, 32'h1);
    chk("fl_valid_clear", {31'b0, inst_valid}, 32'h0);
    cyc();
    clear = 1'b0;
    #1;
    chk("fl_req3", {31'b0, inst_IF_req}, 32'h1);
    chk("fl_addr3", inst_IF_addr, 32'h0000_0020);
    cyc();
    #1;
    chk("fl_req4", {31'b0, inst_IF_req}, 32'h1);
    cyc();
    inst_IF_flag = 1'b1;
    inst_IF      = 32'h0000_0113;
    #1;
    chk("fl_fill_valid", {31'b0, inst_valid}, 32'h0);
    chk("fl_fill_req", {31'b0, inst_IF_req}, 32'h0);
    cyc();
    inst_IF_flag = 1'b0;
    inst_IF      = 32'h0;
    fetch_req    = 1'b0;
    hit_chk(32'h0000_0020, 32'h0000_0113, "fl_hit20");

    // clear coincident with completion: filled, not forwarded.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_0024;
    cyc();
    cyc();
    cyc();
    cyc();
    cyc();
    inst_IF_flag = 1'b1;
    inst_IF      = 32'h0000_0197;
    clear        = 1'b1;
    #1;
    chk("cf_valid", {31'b0, inst_valid}, 32'h0);
    cyc();
    inst_IF_flag = 1'b0;
    clear        = 1'b0;
    fetch_req    = 1'b0;
    hit_chk(32'h0000_0024, 32'h0000_0197, "cf_hit24");

    // Memory controller stalled 6 extra cycles.
    miss_seq(32'h0000_0030, 32'h0000_0213, 6, "stall30");
    #1;
    chk("stall_idle_req", {31'b0, inst_IF_req}, 32'h0);
    hit_chk(32'h0000_0030, 32'h0000_0213, "stall_hit30");

    // rdy low during completion: nothing forwarded and the miss persists.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_0034;
    cyc();
    rdy          = 1'b0;
    inst_IF_flag = 1'b1;
    inst_IF      = 32'h0000_0293;
    #1;
    chk("rdy_valid", {31'b0, inst_valid}, 32'h0);
    cyc();
    rdy          = 1'b1;
    inst_IF_flag = 1'b0;
    #1;
    chk("rdy_still_miss", {31'b0, inst_IF_req}, 32'h1);
    cyc();
    inst_IF_flag = 1'b1;
    #1;
    chk("rdy_fwd", inst_out, 32'h0000_0293);
    cyc();
    inst_IF_flag = 1'b0;
    fetch_req    = 1'b0;

    // Asynchronous reset in the middle of a miss for 0x40.
    fetch_req = 1'b1;
    fetch_pc  = 32'h0000_0040;
    cyc();
    #1;
    chk("ar_req_before", {31'b0, inst_IF_req}, 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_req_now", {31'b0, inst_IF_req}, 32'h0);
    chk("ar_addr_now", inst_IF_addr, 32'h0);
    #1;
    rst = 1'b1;
    fetch_pc = 32'h0000_0010;
    #1;
    chk("ar_10_miss", {31'b0, inst_valid}, 32'h0);
    cyc();
    #1;
    chk("ar_10_req", {31'b0, inst_IF_req}, 32'h1);
    chk("ar_10_addr", inst_IF_addr, 32'h0000_0010);
    fetch_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
